// File: rtl/scb_counter_pkg.sv
// Shared definitions for the scoreboard counter checker.
//   scb_mode_e : counter operating modes (up, down, down-by-STEP, load)
//   sat_inc    : saturating increment on a 32-bit container; the caller
//                passes the all-ones value of the real counter width.
package scb_counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DN   = 2'b01,
    MODE_STEP = 2'b10,
    MODE_LOAD = 2'b11
  } scb_mode_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val);
    sat_inc = (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/scb_delay_line.sv
// Fixed-depth shift register carrying a data word plus a valid bit.
//   clk, rst_n : clock (rising edge), asynchronous active-low clear
//   in_data    : word entering the line
//   in_valid   : valid bit entering the line
//   out_data   : word delayed by DEPTH cycles
//   out_valid  : valid bit delayed by DEPTH cycles (0 until the line fills)
// DEPTH = 0 turns the line into a plain wire.
module scb_delay_line #(
  parameter int W     = 6,
  parameter int DEPTH = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic [W-1:0] out_data,
  output logic         out_valid
);

  if (DEPTH == 0) begin : g_wire
    // No stages: clock and clear have nothing to drive.
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst_n};
    assign out_data  = in_data;
    assign out_valid = in_valid;
  end else begin : g_stages
    logic [W-1:0]     data_q [DEPTH];
    logic [W-1:0]     data_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;

    always_comb begin
      data_d[0]  = in_data;
      valid_d    = '0;
      valid_d[0] = in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
        valid_q <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) data_q[i] <= data_d[i];
        valid_q <= valid_d;
      end
    end

    assign out_data  = data_q[DEPTH-1];
    assign out_valid = valid_q[DEPTH-1];
  end

endmodule

// File: rtl/scoreboard_counter_chk.sv
// Golden model of the up/down/step/load counter with a built-in checker.
// The model's registered {Q, rco, load} is delayed by DUT_LAT cycles and
// compared against the DUT's outputs; mismatch/match statistics are kept.
//   clk, reset            : clock (rising edge), async active-low reset
//   scb_enable, scb_mode  : model enable and mode (see scb_mode_e)
//   scb_D                 : load value for MODE_LOAD
//   chk_en                : compare enable
//   dut_Q/dut_rco/dut_load: DUT outputs under check
//   scb_Q/scb_rco/scb_load: undelayed model outputs
//   err_pulse             : registered one-cycle mismatch strobe
//   err_sticky            : set on first mismatch until reset
//   err_count/match_count : saturating statistics
//   first_err_Q           : delayed model Q at the first mismatch
module scoreboard_counter_chk
  import scb_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int STEP    = 3,
  parameter int DUT_LAT = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scb_enable,
  input  logic [1:0]       scb_mode,
  input  logic [WIDTH-1:0] scb_D,
  input  logic             chk_en,
  input  logic [WIDTH-1:0] dut_Q,
  input  logic             dut_rco,
  input  logic             dut_load,
  output logic [WIDTH-1:0] scb_Q,
  output logic             scb_rco,
  output logic             scb_load,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] match_count,
  output logic [WIDTH-1:0] first_err_Q
);

  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] Q_MAX  = '1;
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [31:0] CNT_MAX =
    (CNT_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << CNT_W) - 32'd1);

  // Model state
  logic [WIDTH-1:0] q_q, q_d;
  logic             rco_q, rco_d;
  logic             load_q, load_d;

  always_comb begin
    q_d    = q_q;
    rco_d  = 1'b0;
    load_d = 1'b0;
    if (scb_enable) begin
      case (scb_mode_e'(scb_mode))
        MODE_UP: begin
          q_d   = q_q + ONE;
          rco_d = (q_q == Q_MAX);
        end
        MODE_DN: begin
          q_d   = q_q - ONE;
          rco_d = (q_q == '0);
        end
        MODE_STEP: begin
          q_d   = q_q - STEP_W;
          rco_d = (q_q < STEP_W);   // borrow out of the subtraction
        end
        MODE_LOAD: begin
          q_d    = scb_D;
          load_d = 1'b1;            // load never raises rco
        end
        default: q_d = q_q;
      endcase
    end
  end

  // Delay line: the valid bit entering is constant 1 once out of reset,
  // so after reset it takes DUT_LAT cycles before compares resume.
  logic [WIDTH+1:0] dly_data;
  logic             dly_valid;

  scb_delay_line #(.W(WIDTH + 2), .DEPTH(DUT_LAT)) u_dly (
    .clk      (clk),
    .rst_n    (reset),
    .in_data  ({q_q, rco_q, load_q}),
    .in_valid (1'b1),
    .out_data (dly_data),
    .out_valid(dly_valid)
  );

  // Comparator and statistics
  logic             cmp_en, cmp_err, cmp_ok;
  logic             err_pulse_q, err_pulse_d;
  logic             err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] match_count_q, match_count_d;
  logic [WIDTH-1:0] first_err_q_q, first_err_q_d;

  assign cmp_en  = dly_valid & chk_en;
  assign cmp_err = cmp_en & (dly_data != {dut_Q, dut_rco, dut_load});
  assign cmp_ok  = cmp_en & ~cmp_err;

  always_comb begin
    err_pulse_d   = cmp_err;
    err_sticky_d  = err_sticky_q | cmp_err;
    err_count_d   = err_count_q;
    match_count_d = match_count_q;
    first_err_q_d = first_err_q_q;
    if (cmp_err) err_count_d = CNT_W'(sat_inc(32'(err_count_q), CNT_MAX));
    if (cmp_ok) match_count_d = CNT_W'(sat_inc(32'(match_count_q), CNT_MAX));
    if (cmp_err && !err_sticky_q) first_err_q_d = dly_data[WIDTH+1:2];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q           <= '0;
      rco_q         <= 1'b0;
      load_q        <= 1'b0;
      err_pulse_q   <= 1'b0;
      err_sticky_q  <= 1'b0;
      err_count_q   <= '0;
      match_count_q <= '0;
      first_err_q_q <= '0;
    end else begin
      q_q           <= q_d;
      rco_q         <= rco_d;
      load_q        <= load_d;
      err_pulse_q   <= err_pulse_d;
      err_sticky_q  <= err_sticky_d;
      err_count_q   <= err_count_d;
      match_count_q <= match_count_d;
      first_err_q_q <= first_err_q_d;
    end
  end

  assign scb_Q       = q_q;
  assign scb_rco     = rco_q;
  assign scb_load    = load_q;
  assign err_pulse   = err_pulse_q;
  assign err_sticky  = err_sticky_q;
  assign err_count   = err_count_q;
  assign match_count = match_count_q;
  assign first_err_Q = first_err_q_q;

endmodule

// File: tb/tb_scoreboard_counter_chk.sv
module tb_scoreboard_counter_chk;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // shared model stimulus
  logic       scb_enable = 1'b0;
  logic [1:0] scb_mode   = 2'b00;
  logic [3:0] scb_D      = 4'h0;

  // main instance (defaults: DUT_LAT=0, CNT_W=16)
  logic        chk_en_m = 1'b0;
  logic [3:0]  dut_q_m = 4'h0;
  logic        dut_rco_m = 1'b0, dut_load_m = 1'b0;
  logic [3:0]  scb_q_m, first_err_q_m;
  logic        scb_rco_m, scb_load_m, err_pulse_m, err_sticky_m;
  logic [15:0] err_count_m, match_count_m;

  // latency-2 instance
  logic        chk_en_l = 1'b0;
  logic [3:0]  dut_q_l = 4'h0;
  logic        dut_rco_l = 1'b0, dut_load_l = 1'b0;
  logic [3:0]  scb_q_l, first_err_q_l;
  logic        scb_rco_l, scb_load_l, err_pulse_l, err_sticky_l;
  logic [15:0] err_count_l, match_count_l;

  // narrow-counter instance (CNT_W=3)
  logic        chk_en_s = 1'b0;
  logic [3:0]  dut_q_s = 4'hF;
  logic        dut_rco_s = 1'b0, dut_load_s = 1'b0;
  logic [3:0]  scb_q_s, first_err_q_s;
  logic        scb_rco_s, scb_load_s, err_pulse_s, err_sticky_s;
  logic [2:0]  err_count_s, match_count_s;

  scoreboard_counter_chk u_main (
    .clk(clk), .reset(reset), .scb_enable(scb_enable), .scb_mode(scb_mode),
    .scb_D(scb_D), .chk_en(chk_en_m), .dut_Q(dut_q_m), .dut_rco(dut_rco_m),
    .dut_load(dut_load_m), .scb_Q(scb_q_m), .scb_rco(scb_rco_m),
    .scb_load(scb_load_m), .err_pulse(err_pulse_m), .err_sticky(err_sticky_m),
    .err_count(err_count_m), .match_count(match_count_m),
    .first_err_Q(first_err_q_m)
  );

  scoreboard_counter_chk #(.DUT_LAT(2)) u_lat2 (
    .clk(clk), .reset(reset), .scb_enable(scb_enable), .scb_mode(scb_mode),
    .scb_D(scb_D), .chk_en(chk_en_l), .dut_Q(dut_q_l), .dut_rco(dut_rco_l),
    .dut_load(dut_load_l), .scb_Q(scb_q_l), .scb_rco(scb_rco_l),
    .scb_load(scb_load_l), .err_pulse(err_pulse_l), .err_sticky(err_sticky_l),
    .err_count(err_count_l), .match_count(match_count_l),
    .first_err_Q(first_err_q_l)
  );

  scoreboard_counter_chk #(.CNT_W(3)) u_sat (
    .clk(clk), .reset(reset), .scb_enable(scb_enable), .scb_mode(scb_mode),
    .scb_D(scb_D), .chk_en(chk_en_s), .dut_Q(dut_q_s), .dut_rco(dut_rco_s),
    .dut_load(dut_load_s), .scb_Q(scb_q_s), .scb_rco(scb_rco_s),
    .scb_load(scb_load_s), .err_pulse(err_pulse_s), .err_sticky(err_sticky_s),
    .err_count(err_count_s), .match_count(match_count_s),
    .first_err_Q(first_err_q_s)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic [3:0] d;
    logic [3:0] q;
    logic       rco;
    logic       load;
    logic [5:0] corrupt;  // xor mask applied to {q,rco,load} for the DUT side
  } vec_t;

  localparam int NVEC = 32;
  vec_t vecs [NVEC];

  task automatic set_vec(input int i, input logic en, input logic [1:0] mode,
                         input logic [3:0] d, input logic [3:0] q,
                         input logic rco, input logic load,
                         input logic [5:0] corrupt);
    vecs[i].en = en; vecs[i].mode = mode; vecs[i].d = d;
    vecs[i].q = q; vecs[i].rco = rco; vecs[i].load = load;
    vecs[i].corrupt = corrupt;
  endtask

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- test ----------------
  initial begin
    int exp_errs;
    int k;

    // up count 0 -> 15 -> 0
    for (int i = 0; i < 16; i++)
      set_vec(i, 1'b1, 2'b00, 4'h0, 4'((i + 1) % 16), (i == 15), 1'b0, 6'h00);
    set_vec(16, 1'b1, 2'b01, 4'h0, 4'hF, 1'b1, 1'b0, 6'h00); // 0 -1 -> F
    set_vec(17, 1'b1, 2'b11, 4'h2, 4'h2, 1'b0, 1'b1, 6'h00);
    set_vec(18, 1'b1, 2'b10, 4'h0, 4'hF, 1'b1, 1'b0, 6'h00); // 2 -3 -> F borrow
    set_vec(19, 1'b1, 2'b11, 4'h3, 4'h3, 1'b0, 1'b1, 6'h00);
    set_vec(20, 1'b1, 2'b10, 4'h0, 4'h0, 1'b0, 1'b0, 6'h00); // 3 -3 -> 0
    set_vec(21, 1'b1, 2'b11, 4'hA, 4'hA, 1'b0, 1'b1, 6'h00);
    set_vec(22, 1'b1, 2'b00, 4'h0, 4'hB, 1'b0, 1'b0, 6'h00);
    set_vec(23, 1'b0, 2'b00, 4'h0, 4'hB, 1'b0, 1'b0, 6'h00); // hold
    set_vec(24, 1'b1, 2'b11, 4'h4, 4'h4, 1'b0, 1'b1, 6'h00);
    set_vec(25, 1'b1, 2'b00, 4'h0, 4'h5, 1'b0, 1'b0, 6'h04); // DUT Q wrong
    set_vec(26, 1'b1, 2'b00, 4'h0, 4'h6, 1'b0, 1'b0, 6'h00);
    set_vec(27, 1'b1, 2'b01, 4'h0, 4'h5, 1'b0, 1'b0, 6'h00);
    set_vec(28, 1'b1, 2'b11, 4'h8, 4'h8, 1'b0, 1'b1, 6'h01); // DUT load wrong
    set_vec(29, 1'b1, 2'b10, 4'h0, 4'h5, 1'b0, 1'b0, 6'h00);
    set_vec(30, 1'b1, 2'b11, 4'hF, 4'hF, 1'b0, 1'b1, 6'h00);
    set_vec(31, 1'b1, 2'b00, 4'h0, 4'h0, 1'b1, 1'b0, 6'h00);

    // ---- reset state ----
    #1 reset = 1'b0;
    chk_en_m = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_q", 32'(scb_q_m), 32'h0);
    check("rst_rco_load", 32'({scb_rco_m, scb_load_m}), 32'h0);
    check("rst_err", 32'({err_pulse_m, err_sticky_m}), 32'h0);
    check("rst_err_count", 32'(err_count_m), 32'h0);
    check("rst_match_count", 32'(match_count_m), 32'h0);
    check("rst_first_err_q", 32'(first_err_q_m), 32'h0);
    reset = 1'b1;

    // ---- main table, DUT mirrored with planted mismatches ----
    exp_errs = 0;
    for (int i = 0; i < NVEC; i++) begin
      scb_enable = vecs[i].en;
      scb_mode   = vecs[i].mode;
      scb_D      = vecs[i].d;
      step();
      {dut_q_m, dut_rco_m, dut_load_m} =
        {vecs[i].q, vecs[i].rco, vecs[i].load} ^ vecs[i].corrupt;
      if (i > 0 && vecs[i-1].corrupt != 6'h00) exp_errs++;
      check($sformatf("v%0d_q", i), 32'(scb_q_m), 32'(vecs[i].q));
      check($sformatf("v%0d_rco", i), 32'(scb_rco_m), 32'(vecs[i].rco));
      check($sformatf("v%0d_load", i), 32'(scb_load_m), 32'(vecs[i].load));
      check($sformatf("v%0d_err_pulse", i), 32'(err_pulse_m),
            (i > 0 && vecs[i-1].corrupt != 6'h00) ? 32'h1 : 32'h0);
      check($sformatf("v%0d_err_count", i), 32'(err_count_m), 32'(exp_errs));
    end
    scb_enable = 1'b0;
    step();                // registers the compare of the last vector
    chk_en_m = 1'b0;
    check("main_last_pulse", 32'(err_pulse_m), 32'h0);
    check("main_err_count", 32'(err_count_m), 32'd2);
    check("main_match_count", 32'(match_count_m), 32'd31);
    check("main_err_sticky", 32'(err_sticky_m), 32'h1);
    check("main_first_err_q", 32'(first_err_q_m), 32'h5);
    repeat (3) step();
    check("main_hold_match", 32'(match_count_m), 32'd31);
    check("main_hold_err", 32'(err_count_m), 32'd2);

    // ---- DUT_LAT=2 with a DUT delayed by two cycles ----
    scb_enable = 1'b1;
    scb_mode   = 2'b00;
    dut_q_l = 4'h0; dut_rco_l = 1'b0; dut_load_l = 1'b0;
    pulse_reset();
    chk_en_l = 1'b1;
    for (int e = 1; e <= 50; e++) begin
      step();
      k = e - 2;
      if (k >= 0) begin
        dut_q_l   = 4'(k % 16);
        dut_rco_l = (k >= 16) && (k % 16 == 0);
      end
      check($sformatf("lat_e%0d_q", e), 32'(scb_q_l), 32'(e % 16));
      check($sformatf("lat_e%0d_pulse", e), 32'(err_pulse_l), 32'h0);
    end
    check("lat_match_count", 32'(match_count_l), 32'd48);
    check("lat_err_count", 32'(err_count_l), 32'd0);
    check("lat_err_sticky", 32'(err_sticky_l), 32'h0);
    chk_en_l = 1'b0;
    repeat (5) step();
    check("lat_hold_match", 32'(match_count_l), 32'd48);

    // ---- CNT_W=3 saturation under persistent mismatch ----
    dut_q_s = 4'hF;
    pulse_reset();
    for (int e = 1; e <= 12; e++) begin
      step();
      if (e == 2) chk_en_s = 1'b1;  // compares registered on edges 3..12
      check($sformatf("sat_e%0d_count", e), 32'(err_count_s),
            (e <= 2) ? 32'd0 : ((e - 2 > 7) ? 32'd7 : 32'(e - 2)));
      check($sformatf("sat_e%0d_q", e), 32'(scb_q_s), 32'(e));
    end
    check("sat_err_sticky", 32'(err_sticky_s), 32'h1);
    check("sat_first_err_q", 32'(first_err_q_s), 32'h2);
    check("sat_match_count", 32'(match_count_s), 32'h0);
    check("sat_err_pulse", 32'(err_pulse_s), 32'h1);

    // ---- asynchronous reset mid-run ----
    #2;
    reset = 1'b0;
    #1;
    check("arst_sat_q", 32'(scb_q_s), 32'h0);
    check("arst_sat_err_count", 32'(err_count_s), 32'h0);
    check("arst_sat_sticky_pulse", 32'({err_sticky_s, err_pulse_s}), 32'h0);
    check("arst_sat_first_err_q", 32'(first_err_q_s), 32'h0);
    check("arst_main_q", 32'(scb_q_m), 32'h0);
    check("arst_lat_match", 32'(match_count_l), 32'h0);
    check("arst_lat_q", 32'(scb_q_l), 32'h0);
    chk_en_s = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step();
    check("post_rst_sat_count", 32'(err_count_s), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
